// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI main controller and its sclk generator.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int unsigned cs_width(input int unsigned num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sclk generator: CLK_DIV prescaler plus sclk edge counter, with one-cycle strobes
// marking the clk edge on which each sclk toggle is produced.
module spi_clk_gen import spi_pkg::*; #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic idle_lvl_i,
    input  logic run_lvl_i,
    output logic tick_o,
    output logic lead_stb_o,
    output logic trail_stb_o,
    output logic last_stb_o,
    output logic sclk_o
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGES   = EDGE_W'(2 * DATA_W);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              tick, toggle;

    always_comb begin
        tick   = run_i && (div_q == DIV_MAX);
        toggle = tick && (edge_q != EDGES);
        div_d  = '0;
        edge_d = '0;
        sclk_d = idle_lvl_i;
        if (run_i) begin
            div_d  = tick ? '0 : div_q + 1'b1;
            edge_d = toggle ? edge_q + 1'b1 : edge_q;
            // Odd edge count means sclk sits at the non-idle level.
            sclk_d = run_lvl_i ^ edge_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign tick_o      = tick;
    assign lead_stb_o  = toggle && !edge_q[0];
    assign trail_stb_o = toggle && edge_q[0];
    assign last_stb_o  = toggle && (edge_q == EDGES - 1'b1);
    assign sclk_o      = sclk_q;

endmodule

// File: rtl/spi_main_ctrl.sv
// SPI main controller: one DATA_W-bit full-duplex transfer per start/done handshake.
// Optional SPI_MAIN_LSB_FIRST_EN adds a per-transfer lsb_first_i bit-order select.
module spi_main_ctrl import spi_pkg::*; #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CS  = 1,
    parameter int unsigned CS_W    = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [CS_W-1:0]   cs_sel_i,
`ifdef SPI_MAIN_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    input  logic              miso_i,
    output logic [DATA_W-1:0] rx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_CS-1:0] cs_n_o
);

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic              busy_q, done_q, mosi_q;
    logic [NUM_CS-1:0] cs_n_q;
    logic              lsb_in;
    logic              tick, lead_stb, trail_stb, last_stb;

`ifdef SPI_MAIN_LSB_FIRST_EN
    assign lsb_in = lsb_first_i;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // Out-of-range selects leave every line deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(sel) == i) m[i] = 1'b0;
        end
        return m;
    endfunction

    spi_clk_gen #(
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q != StIdle),
        .idle_lvl_i (cpol_i),
        .run_lvl_i  (cpol_q),
        .tick_o     (tick),
        .lead_stb_o (lead_stb),
        .trail_stb_o(trail_stb),
        .last_stb_o (last_stb),
        .sclk_o     (sclk_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    mosi_q <= 1'b0;
                    cs_n_q <= '1;
                    busy_q <= 1'b0;
                    // busy_q is still high in the done cycle, so accepts start one cycle later.
                    if (start_i && !busy_q) begin
                        state_q <= StSetup;
                        busy_q  <= 1'b1;
                        cpol_q  <= cpol_i;
                        cpha_q  <= cpha_i;
                        lsb_q   <= lsb_in;
                        cs_n_q  <= cs_decode(cs_sel_i);
                        rx_sh_q <= '0;
                        if (!cpha_i) begin
                            mosi_q  <= first_bit(tx_i, lsb_in);
                            tx_sh_q <= shift_out(tx_i, lsb_in);
                        end else begin
                            tx_sh_q <= tx_i;
                        end
                    end
                end
                StSetup, StXfer: begin
                    if (lead_stb) begin
                        state_q <= StXfer;
                        if (cpha_q) begin
                            mosi_q  <= first_bit(tx_sh_q, lsb_q);
                            tx_sh_q <= shift_out(tx_sh_q, lsb_q);
                        end else begin
                            rx_sh_q <= shift_in(rx_sh_q, miso_i, lsb_q);
                        end
                    end else if (trail_stb) begin
                        if (last_stb) state_q <= StHold;
                        if (cpha_q) begin
                            rx_sh_q <= shift_in(rx_sh_q, miso_i, lsb_q);
                        end else if (!last_stb) begin
                            mosi_q  <= first_bit(tx_sh_q, lsb_q);
                            tx_sh_q <= shift_out(tx_sh_q, lsb_q);
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        cs_n_q  <= '1;
                        rx_q    <= rx_sh_q;
                        mosi_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rx_o   = rx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign mosi_o = mosi_q;
    assign cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_main_ctrl.sv
// Self-checking bench for spi_main_ctrl: vector table, randomized transfers against a
// cycle/bit-level model, a behavioural SPI target, and hand-written corner sequences.
module tb_spi_main_ctrl;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NCS  = 4;
    localparam int CSW  = 3;
    localparam int LAST = 1 + (2 * W + 1) * D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] tx;
    logic         cpol, cpha;
    logic [CSW-1:0] cs_sel;
    logic         miso;
    logic [W-1:0] rx;
    logic         busy, done, sclk, mosi;
    logic [NCS-1:0] cs_n;
`ifdef SPI_MAIN_LSB_FIRST_EN
    logic         lsb_first = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Target model state.
    logic         cur_loop = 1'b1, cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
    logic [W-1:0] tgt_word = '0, slv_rcv = '0;
    logic         miso_slv = 1'b0, slv_prev_sel = 1'b0, sclk_prev = 1'b0;
    int           slave_cs = 0, slv_drv = 0;

    always #5 clk = ~clk;

    spi_main_ctrl #(
        .DATA_W (W),
        .CLK_DIV(D),
        .NUM_CS (NCS),
        .CS_W   (CSW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .tx_i       (tx),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .cs_sel_i   (cs_sel),
`ifdef SPI_MAIN_LSB_FIRST_EN
        .lsb_first_i(lsb_first),
`endif
        .miso_i     (miso),
        .rx_o       (rx),
        .busy_o     (busy),
        .done_o     (done),
        .sclk_o     (sclk),
        .mosi_o     (mosi),
        .cs_n_o     (cs_n)
    );

    assign miso = cur_loop ? mosi : miso_slv;

    function automatic logic tgt_bit(input int i);
        return cur_lsb ? tgt_word[i] : tgt_word[W-1-i];
    endfunction

    // Behavioural SPI target: shifts tgt_word out and captures mosi per the selected mode.
    always @(negedge clk) begin
        logic sel_now, lead;
        sel_now = 1'b0;
        if (slave_cs < NCS) sel_now = !cs_n[slave_cs];
        if (!sel_now) begin
            miso_slv = 1'b0;
        end else if (!slv_prev_sel) begin
            slv_rcv  = '0;
            slv_drv  = cur_cpha ? 0 : 1;
            miso_slv = cur_cpha ? 1'b0 : tgt_bit(0);
        end else if (sclk != sclk_prev) begin
            lead = (sclk_prev == cur_cpol);
            if (lead ^ cur_cpha) begin
                slv_rcv = cur_lsb ? {mosi, slv_rcv[W-1:1]} : {slv_rcv[W-2:0], mosi};
            end else if (slv_drv < W) begin
                miso_slv = tgt_bit(slv_drv);
                slv_drv++;
            end
        end
        slv_prev_sel = sel_now;
        sclk_prev    = sclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_xfer(input string nm, input logic [W-1:0] t, input logic pol,
                           input logic pha, input logic [CSW-1:0] sel, input logic lp,
                           input logic [W-1:0] tgt, input logic lsb, input logic [W-1:0] exp_rx);
        int e_sclk, e_mosi, e_cs, e_busy, e_done, rises, togg, lead_n, idx;
        logic prev_sclk, exp_mosi;
        logic [NCS-1:0] sel_mask, exp_cs;
        logic [W-1:0] bits;
        e_sclk = 0; e_mosi = 0; e_cs = 0; e_busy = 0; e_done = 0; rises = 0;
        for (int i = 0; i < W; i++) bits[i] = lsb ? t[i] : t[W-1-i];
        sel_mask = ~(4'b0001 << sel);
        cur_loop = lp; cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb;
        tgt_word = tgt; slave_cs = int'(sel);
        tx = t; cpol = pol; cpha = pha; cs_sel = sel;
`ifdef SPI_MAIN_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        repeat (3) @(negedge clk);
        chk({nm, " idle_sclk"}, 32'(sclk), 32'(pol));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        prev_sclk = pol;
        for (int c = 1; c <= LAST + 1; c++) begin
            @(negedge clk);
            togg = (c - 1) / D;
            if (togg > 2 * W) togg = 2 * W;
            if (sclk !== (pol ^ togg[0])) e_sclk++;
            if (c >= LAST) begin
                exp_mosi = 1'b0;
            end else if (!pha) begin
                idx = (togg / 2 < W - 1) ? togg / 2 : W - 1;
                exp_mosi = bits[idx];
            end else begin
                lead_n = (togg + 1) / 2;
                exp_mosi = (lead_n == 0) ? 1'b0 : bits[lead_n-1];
            end
            if (mosi !== exp_mosi) e_mosi++;
            exp_cs = (c < LAST) ? sel_mask : '1;
            if (cs_n !== exp_cs) e_cs++;
            if (busy !== (c <= LAST)) e_busy++;
            if (done !== (c == LAST)) e_done++;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
        end
        chk({nm, " sclk_err_cycles"}, e_sclk, 0);
        chk({nm, " mosi_err_cycles"}, e_mosi, 0);
        chk({nm, " cs_n_err_cycles"}, e_cs, 0);
        chk({nm, " busy_err_cycles"}, e_busy, 0);
        chk({nm, " done_err_cycles"}, e_done, 0);
        chk({nm, " sclk_rises"}, rises, W);
        chk({nm, " rx"}, 32'(rx), 32'(exp_rx));
        if (!lp && sel < NCS) chk({nm, " target_rx"}, 32'(slv_rcv), 32'(t));
    endtask

    typedef struct {
        string        nm;
        logic [W-1:0] t;
        logic         pol;
        logic         pha;
        logic [CSW-1:0] sel;
        logic         lp;
        logic [W-1:0] tgt;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nd, found;
        logic drop_busy, re_busy, re_cs;

        vecs[0] = '{"m0_loop_a5",  8'hA5, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'hA5};
        vecs[1] = '{"m3_tgt_c3",   8'h3C, 1'b1, 1'b1, 3'd0, 1'b0, 8'hC3, 8'hC3};
        vecs[2] = '{"m1_cs2",      8'h96, 1'b0, 1'b1, 3'd2, 1'b0, 8'h5A, 8'h5A};
        vecs[3] = '{"m2_cs5_none", 8'hE1, 1'b1, 1'b0, 3'd5, 1'b0, 8'h77, 8'h00};
        vecs[4] = '{"m3_loop_0f",  8'h0F, 1'b1, 1'b1, 3'd3, 1'b1, 8'h00, 8'h0F};
        vecs[5] = '{"m0_cs1_ff",   8'h80, 1'b0, 1'b0, 3'd1, 1'b0, 8'hFF, 8'hFF};

        rst_n = 1'b0; start = 1'b0; tx = '0; cpol = 1'b1; cpha = 1'b0; cs_sel = '0;
        repeat (2) @(negedge clk);
        chk("reset sclk", 32'(sclk), 0);
        chk("reset mosi", 32'(mosi), 0);
        chk("reset cs_n", 32'(cs_n), 32'hF);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset rx", 32'(rx), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_xfer(vecs[v].nm, vecs[v].t, vecs[v].pol, vecs[v].pha, vecs[v].sel,
                    vecs[v].lp, vecs[v].tgt, 1'b0, vecs[v].exp_rx);
        end

        for (int n = 0; n < 16; n++) begin
            logic [W-1:0] rt, rtg, rexp;
            logic [CSW-1:0] rs;
            logic rpol, rpha, rlp, rlsb;
            rt   = W'($urandom);
            rtg  = W'($urandom);
            rpol = 1'($urandom);
            rpha = 1'($urandom);
            rlp  = 1'($urandom);
            rs   = CSW'($urandom_range(0, 5));
            rlsb = 1'b0;
`ifdef SPI_MAIN_LSB_FIRST_EN
            rlsb = 1'($urandom);
`endif
            rexp = rlp ? rt : ((rs < NCS) ? rtg : '0);
            do_xfer($sformatf("rand%0d", n), rt, rpol, rpha, rs, rlp, rtg, rlsb, rexp);
        end

        // start held high: one done per transfer, re-accept in the cycle after done.
        tx = 8'h5A; cpol = 1'b0; cpha = 1'b0; cs_sel = '0;
        cur_loop = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0; slave_cs = 0;
`ifdef SPI_MAIN_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        nd = 0; drop_busy = 1'b1; re_busy = 1'b0; re_cs = 1'b1;
        for (int c = 1; c <= LAST + 2; c++) begin
            @(negedge clk);
            if (c == 10) start = 1'b1;
            if (c <= LAST + 1 && done) nd++;
            if (c == LAST + 1) drop_busy = busy;
            if (c == LAST + 2) begin
                re_busy = busy;
                re_cs   = cs_n[0];
            end
        end
        start = 1'b0;
        chk("held_start done_count", nd, 1);
        chk("held_start busy_after_done", 32'(drop_busy), 0);
        chk("held_start reaccept_busy", 32'(re_busy), 1);
        chk("held_start reaccept_cs_n0", 32'(re_cs), 0);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        chk("held_start second_done", found, 1);
        chk("held_start second_rx", 32'(rx), 32'h5A);

        // Asynchronous reset in cycle 12 of a transfer.
        tx = 8'hC5; cpol = 1'b1; cpha = 1'b0; cs_sel = 3'd1; slave_cs = 1;
        cur_cpol = 1'b1; cur_loop = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset cs_n", 32'(cs_n), 32'hF);
        chk("mid_reset sclk", 32'(sclk), 0);
        chk("mid_reset busy", 32'(busy), 0);
        chk("mid_reset rx", 32'(rx), 0);
        chk("mid_reset done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("mid_reset no_activity_after", nd, 0);
        do_xfer("post_reset", 8'h6B, 1'b0, 1'b1, 3'd1, 1'b0, 8'h94, 1'b0, 8'h94);

`ifdef SPI_MAIN_LSB_FIRST_EN
        do_xfer("lsb_loop_01", 8'h01, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 8'h01);
        do_xfer("lsb_tgt_m3", 8'h2D, 1'b1, 1'b1, 3'd2, 1'b0, 8'hB1, 1'b1, 8'hB1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
